// File: rtl/path_string_stream_pkg.sv
// path_pkg: shared state encoding, ASCII digit base and decimal power helper.
package path_pkg;

    typedef enum logic [1:0] {IDLE, CONVERT, STREAM} state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;

    function automatic int unsigned pow10(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/path_string_stream_bcd.sv
// bcd_double_dabble_seq: sequential binary-to-BCD converter, one shift per cycle.
// The load cycle performs the first shift, so busy drops after INDEX_WIDTH-1 further cycles.
module bcd_double_dabble_seq #(
    parameter int INDEX_WIDTH = 7,
    parameter int DIGITS      = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [INDEX_WIDTH-1:0] value,
    output logic                   busy,
    output logic [4*DIGITS-1:0]    bcd
);
    import path_pkg::*;

    localparam int CW = $clog2(INDEX_WIDTH + 1);

    logic [INDEX_WIDTH-1:0] sh;
    logic [CW-1:0]          cnt;
    logic [4*DIGITS-1:0]    adj;

    assign busy = cnt != '0;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    end

    // Nibbles above DIGITS are dropped, leaving value mod 10^DIGITS.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sh  <= '0;
            cnt <= '0;
            bcd <= '0;
        end else if (load) begin
            sh  <= value << 1;
            cnt <= CW'(INDEX_WIDTH - 1);
            bcd <= {{(4*DIGITS-1){1'b0}}, value[INDEX_WIDTH-1]};
        end else if (busy) begin
            sh  <= sh << 1;
            cnt <= cnt - 1'b1;
            bcd <= {adj[4*DIGITS-2:0], sh[INDEX_WIDTH-1]};
        end

endmodule

// File: rtl/path_string_stream.sv
// path_string_stream: streams PREFIX + decimal index + SUFFIX one byte per handshake.
module path_string_stream #(
    parameter int                        PREFIX_LEN  = 26,
    parameter logic [8*PREFIX_LEN-1:0]   PREFIX      = "/Saves/camera/common/SRAM_",
    parameter int                        SUFFIX_LEN  = 4,
    parameter logic [8*SUFFIX_LEN-1:0]   SUFFIX      = ".sav",
    parameter int                        INDEX_WIDTH = 7,
    parameter int                        DIGITS      = 2,
    parameter int                        ZERO_PAD    = 1,
    parameter int                        LEN_W       = $clog2(PREFIX_LEN + DIGITS + SUFFIX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] index,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [4*DIGITS-1:0]    index_bcd,
    output logic [LEN_W-1:0]       path_len,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
);
    import path_pkg::*;

    localparam int unsigned LIMIT = pow10(DIGITS);

    state_t                 state, state_n;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [LEN_W-1:0]       p;
    logic                   load, bcd_busy;
    int                     nd, total;

    assign load = state == IDLE && start;
    assign busy = state != IDLE;

    bcd_double_dabble_seq #(.INDEX_WIDTH(INDEX_WIDTH), .DIGITS(DIGITS)) u_bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .value   (index),
        .busy    (bcd_busy),
        .bcd     (index_bcd)
    );

    // Emitted digit count: highest non-zero nibble position, at least one digit.
    always_comb begin
        nd = 1;
        for (int i = 1; i < DIGITS; i++)
            if (ZERO_PAD != 0 || index_bcd[4*i+:4] != 4'd0) nd = i + 1;
        total = PREFIX_LEN + nd + SUFFIX_LEN;
    end

    function automatic logic [7:0] byte_at(input int q, input int n, input logic [4*DIGITS-1:0] b);
        logic [8*PREFIX_LEN-1:0] ps;
        logic [8*SUFFIX_LEN-1:0] ss;
        logic [4*DIGITS-1:0]     bs;
        ps = PREFIX << (8 * q);
        ss = SUFFIX << (8 * (q - PREFIX_LEN - n));
        bs = b >> (4 * (PREFIX_LEN + n - 1 - q));
        if (q < PREFIX_LEN) return ps[8*PREFIX_LEN-1 -: 8];
        if (q < PREFIX_LEN + n) return ASCII_ZERO + {4'h0, bs[3:0]};
        return ss[8*SUFFIX_LEN-1 -: 8];
    endfunction

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? CONVERT : IDLE;
            CONVERT: state_n = bcd_busy ? CONVERT : STREAM;
            default: state_n = out_valid && out_ready && out_last ? IDLE : STREAM;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state     <= IDLE;
            index_q   <= '0;
            overflow  <= 1'b0;
            path_len  <= '0;
            p         <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            if (load) begin
                index_q  <= index;
                overflow <= 1'b0;
            end
            if (state == CONVERT && !bcd_busy) begin
                overflow  <= 32'(index_q) >= LIMIT;
                path_len  <= LEN_W'(total);
                p         <= '0;
                out_data  <= byte_at(0, nd, index_bcd);
                out_valid <= 1'b1;
                out_last  <= total == 1;
            end
            if (state == STREAM && out_valid && out_ready) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    p        <= p + 1'b1;
                    out_data <= byte_at(int'(p) + 1, nd, index_bcd);
                    out_last <= int'(p) + 2 == int'(path_len);
                end
            end
        end

endmodule

// File: tb/tb_path_string_stream.sv
// tb_path_string_stream: scoreboard bench for two configurations of path_string_stream.
// Instance 0 uses defaults; instance 1 uses INDEX_WIDTH=10, DIGITS=3, ZERO_PAD=0.
module tb_path_string_stream;

    typedef struct {
        int len;
        int ovf;
        int bcd;
    } txn_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       start_i = '0;
    logic [1:0][9:0]  idx_i = '0;
    logic [1:0]       ready_i = '1;
    logic [1:0]       rnd = '0;
    logic [1:0]       busy_o, done_o, ovf_o, out_valid_o, last_o;
    logic [1:0][7:0]  data_o;
    logic [1:0][5:0]  len_o;
    logic [7:0]       bcd0;
    logic [11:0]      bcd1;

    logic [7:0] bq[2][$];
    txn_t       mq[2][$];
    int         k[2];
    logic [1:0] last_acc = '0;
    logic [1:0] stall = '0;
    logic [7:0] sd[2];
    logic       sl[2];
    logic [7:0] m_e;
    txn_t       m_t;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    path_string_stream u0 (
        .clk(clk), .reset_n(reset_n), .start(start_i[0]), .index(idx_i[0][6:0]),
        .busy(busy_o[0]), .done(done_o[0]), .overflow(ovf_o[0]), .index_bcd(bcd0),
        .path_len(len_o[0]), .out_data(data_o[0]), .out_valid(out_valid_o[0]),
        .out_ready(ready_i[0]), .out_last(last_o[0])
    );

    path_string_stream #(.INDEX_WIDTH(10), .DIGITS(3), .ZERO_PAD(0)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start_i[1]), .index(idx_i[1]),
        .busy(busy_o[1]), .done(done_o[1]), .overflow(ovf_o[1]), .index_bcd(bcd1),
        .path_len(len_o[1]), .out_data(data_o[1]), .out_valid(out_valid_o[1]),
        .out_ready(ready_i[1]), .out_last(last_o[1])
    );

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", n, a, a, e, e, $time);
        end
    endtask

    function automatic int bcd_of(input int i);
        return i != 0 ? int'(bcd1) : int'(bcd0);
    endfunction

    // Reference: the path is built as a string from the decimal value of the index.
    task automatic push_exp(input int i, input int idx);
        int    d, lim, v;
        string s, p;
        txn_t  t;
        d   = i != 0 ? 3 : 2;
        lim = i != 0 ? 1000 : 100;
        v   = idx % lim;
        s   = $sformatf("%0d", v);
        if (i == 0) while (s.len() < d) s = {"0", s};
        p = {"/Saves/camera/common/SRAM_", s, ".sav"};
        for (int j = 0; j < p.len(); j++) bq[i].push_back(p[j]);
        t.len = p.len();
        t.ovf = idx >= lim ? 1 : 0;
        t.bcd = 0;
        for (int j = 0; j < d; j++) t.bcd = t.bcd | (((v / (10 ** j)) % 10) << (4 * j));
        mq[i].push_back(t);
    endtask

    // Called at posedge+1; returns at posedge+1 of the done cycle.
    task automatic go(input int i, input int idx, input bit poke);
        int c, iw;
        iw = i != 0 ? 10 : 7;
        idx_i[i]   = 10'(idx);
        start_i[i] = 1'b1;
        push_exp(i, idx);
        @(posedge clk); #1;
        start_i[i] = 1'b0;
        idx_i[i]   = 10'($urandom);
        chk("busy_rise", int'(busy_o[i]), 1);
        c = 1;
        while (!out_valid_o[i] && c < 40) begin
            start_i[i] = poke && c == 3;
            @(posedge clk); #1;
            c++;
        end
        start_i[i] = 1'b0;
        chk("first_valid_latency", c, iw + 1);
        if (poke) begin
            start_i[i] = 1'b1;
            @(posedge clk); #1;
            start_i[i] = 1'b0;
        end
        c = 0;
        while (!done_o[i] && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        chk("done_seen", int'(done_o[i]), 1);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) ready_i[i] = rnd[i] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                k[i] = 0;
                last_acc[i] = 1'b0;
                stall[i] = 1'b0;
            end else begin
                if (last_acc[i]) begin
                    chk("done_pulse", int'(done_o[i]), 1);
                    chk("idle_after_done", int'(busy_o[i] | out_valid_o[i]), 0);
                    last_acc[i] = 1'b0;
                end else if (done_o[i]) chk("spurious_done", int'(done_o[i]), 0);
                if (stall[i]) begin
                    chk("stall_valid", int'(out_valid_o[i]), 1);
                    chk("stall_data", int'(data_o[i]), int'(sd[i]));
                    chk("stall_last", int'(last_o[i]), int'(sl[i]));
                end
                stall[i] = out_valid_o[i] && !ready_i[i];
                sd[i] = data_o[i];
                sl[i] = last_o[i];
                if (out_valid_o[i] && ready_i[i]) begin
                    if (bq[i].size() == 0 || mq[i].size() == 0) chk("unexpected_byte", int'(out_valid_o[i]), 0);
                    else begin
                        m_e = bq[i].pop_front();
                        m_t = mq[i][0];
                        chk($sformatf("byte%0d_%0d", i, k[i]), int'(data_o[i]), int'(m_e));
                        chk("last_flag", int'(last_o[i]), k[i] == m_t.len - 1 ? 1 : 0);
                        chk("path_len", int'(len_o[i]), m_t.len);
                        if (k[i] == m_t.len - 1) begin
                            chk("overflow", int'(ovf_o[i]), m_t.ovf);
                            chk("index_bcd", bcd_of(i), m_t.bcd);
                            void'(mq[i].pop_front());
                            k[i] = 0;
                            last_acc[i] = 1'b1;
                        end else k[i]++;
                    end
                end
            end
        end
    end

    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", int'(busy_o[i]), 0);
            chk("rst_done", int'(done_o[i]), 0);
            chk("rst_valid", int'(out_valid_o[i]), 0);
            chk("rst_last", int'(last_o[i]), 0);
            chk("rst_data", int'(data_o[i]), 0);
            chk("rst_len", int'(len_o[i]), 0);
            chk("rst_ovf", int'(ovf_o[i]), 0);
            chk("rst_bcd", bcd_of(i), 0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        go(0, 5, 0);
        go(0, 127, 0);
        go(1, 7, 0);
        go(1, 0, 0);
        go(1, 999, 1);
        go(1, 1000, 0);
        go(0, 99, 1);
        rnd = 2'b11;
        repeat (10) go(0, $urandom_range(0, 127), 1'($urandom_range(0, 1)));
        repeat (10) go(1, $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
        rnd = 2'b00;
        @(posedge clk); #1;
        idx_i[0]   = 10'd33;
        start_i[0] = 1'b1;
        push_exp(0, 33);
        @(posedge clk); #1;
        start_i[0] = 1'b0;
        c = 0;
        while (k[0] < 10 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("reach_byte10", k[0], 10);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid_o[0]), 0);
        chk("arst_busy", int'(busy_o[0]), 0);
        chk("arst_data", int'(data_o[0]), 0);
        chk("arst_len", int'(len_o[0]), 0);
        chk("arst_done", int'(done_o[0]), 0);
        bq[0].delete();
        mq[0].delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        go(0, 42, 0);
        go(1, 305, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("queue0_empty", bq[0].size(), 0);
        chk("queue1_empty", bq[1].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
